// File: rtl/fifo_wr_arbiter_if.sv
// Requester-side write ports plus the shared fifo write port and grant status.
// master = requesters/fifo environment, slave = the arbiter.
interface fifo_wr_arbiter_if #(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 8,
    parameter int ID_W       = ($clog2(NUM_REQ) > 1) ? $clog2(NUM_REQ) : 1
) ();
    logic [NUM_REQ-1:0]            req_valid;
    logic [NUM_REQ*DATA_WIDTH-1:0] req_data;
    logic [NUM_REQ-1:0]            req_ready;
    logic                          fifo_wr_ready;
    logic                          fifo_wr_en;
    logic [DATA_WIDTH-1:0]         fifo_wr_data;
    logic                          gnt_val;
    logic [ID_W-1:0]               gnt_id;

    modport master (
        output req_valid,
        output req_data,
        output fifo_wr_ready,
        input  req_ready,
        input  fifo_wr_en,
        input  fifo_wr_data,
        input  gnt_val,
        input  gnt_id
    );

    modport slave (
        input  req_valid,
        input  req_data,
        input  fifo_wr_ready,
        output req_ready,
        output fifo_wr_en,
        output fifo_wr_data,
        output gnt_val,
        output gnt_id
    );
endinterface

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one fifo write port; 1-cycle arbitration, 0-cycle write path.
// Backpressure: fifo_wr_ready=0 holds the grant with no beat; burst count frozen until ready.
module fifo_wr_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 8,
    parameter int MAX_BURST  = 4,
    parameter int ID_W       = ($clog2(NUM_REQ) > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic             clk,
    input  logic             reset_n,
    fifo_wr_arbiter_if.slave bus
);
    localparam int               CNT_W     = $clog2(MAX_BURST) + 1;
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(MAX_BURST - 1);

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } state_t;

    state_t            r_state;
    logic              r_gnt_val;
    logic [ID_W-1:0]   r_gnt_id;
    logic [ID_W-1:0]   r_rr_ptr;
    logic [CNT_W-1:0]  r_beat_cnt;

    logic                  w_pick_vld;
    logic [ID_W-1:0]       w_pick_id;
    logic [ID_W-1:0]       w_next_ptr;
    logic                  w_cur_vld;
    logic [DATA_WIDTH-1:0] w_cur_dat;
    logic [NUM_REQ-1:0]    w_req_rdy;
    logic                  w_beat;
    logic                  w_release;

    // Pick the valid requester closest to the rr pointer, counting upward with wrap.
    always_comb begin
        int d;
        int best_d;
        w_pick_vld = 1'b0;
        w_pick_id  = '0;
        d          = 0;
        best_d     = NUM_REQ;
        for (int i = 0; i < NUM_REQ; i++) begin
            d = (i + NUM_REQ - int'(r_rr_ptr)) % NUM_REQ;
            if (bus.req_valid[i] && (d < best_d)) begin
                best_d     = d;
                w_pick_vld = 1'b1;
                w_pick_id  = ID_W'(i);
            end
        end
    end

    always_comb begin
        w_cur_vld = 1'b0;
        w_cur_dat = '0;
        w_req_rdy = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if ((r_state == ST_GRANT) && (r_gnt_id == ID_W'(i))) begin
                w_cur_vld    = bus.req_valid[i];
                w_cur_dat    = bus.req_data[i*DATA_WIDTH +: DATA_WIDTH];
                w_req_rdy[i] = bus.fifo_wr_ready;
            end
        end
    end

    assign w_beat     = w_cur_vld & bus.fifo_wr_ready;
    assign w_release  = (r_state == ST_GRANT) &
                        (~w_cur_vld | (w_beat & (r_beat_cnt == LAST_BEAT)));
    assign w_next_ptr = (r_gnt_id == ID_W'(NUM_REQ - 1)) ? '0 : (r_gnt_id + ID_W'(1));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state    <= ST_IDLE;
            r_gnt_val  <= 1'b0;
            r_gnt_id   <= '0;
            r_rr_ptr   <= '0;
            r_beat_cnt <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_pick_vld) begin
                        r_state    <= ST_GRANT;
                        r_gnt_val  <= 1'b1;
                        r_gnt_id   <= w_pick_id;
                        r_beat_cnt <= '0;
                    end
                end
                ST_GRANT: begin
                    // Count reaches MAX_BURST at most, which CNT_W holds without wrapping.
                    if (w_beat) begin
                        r_beat_cnt <= r_beat_cnt + CNT_W'(1);
                    end
                    if (w_release) begin
                        r_state   <= ST_IDLE;
                        r_gnt_val <= 1'b0;
                        r_rr_ptr  <= w_next_ptr;
                    end
                end
            endcase
        end
    end

    assign bus.req_ready    = w_req_rdy;
    assign bus.fifo_wr_en   = w_beat;
    assign bus.fifo_wr_data = w_cur_dat;
    assign bus.gnt_val      = r_gnt_val;
    assign bus.gnt_id       = r_gnt_id;

    a_rdy_onehot : assert property (@(posedge clk) disable iff (!reset_n)
        $onehot0(bus.req_ready));
    a_wr_needs_gnt : assert property (@(posedge clk) disable iff (!reset_n)
        bus.fifo_wr_en |-> r_gnt_val);
endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed bench for fifo_wr_arbiter: reset, round-robin, short burst, backpressure,
// fifo-full holding and reset mid-burst, with a depth-8 fifo occupancy model.
module tb_fifo_wr_arbiter;
    localparam int NUM_REQ    = 4;
    localparam int DATA_WIDTH = 8;
    localparam int MAX_BURST  = 4;
    localparam int ID_W       = 2;
    localparam int FIFO_DEPTH = 8;

    logic clk      = 1'b0;
    logic reset_n  = 1'b0;
    logic drv_rdy  = 1'b1;
    logic model_en = 1'b0;
    int   fifo_base = 0;
    int   n_wr      = 0;
    int   n_checks  = 0;
    int   n_errors  = 0;

    logic [DATA_WIDTH-1:0] log_dat [0:1023];
    logic [ID_W-1:0]       log_id  [0:1023];

    fifo_wr_arbiter_if #(.NUM_REQ(NUM_REQ), .DATA_WIDTH(DATA_WIDTH), .ID_W(ID_W)) bus ();

    fifo_wr_arbiter #(
        .NUM_REQ(NUM_REQ), .DATA_WIDTH(DATA_WIDTH), .MAX_BURST(MAX_BURST), .ID_W(ID_W)
    ) dut (
        .clk(clk),
        .reset_n(reset_n),
        .bus(bus)
    );

    always #5 clk = ~clk;

    assign bus.fifo_wr_ready = model_en ? ((n_wr - fifo_base) < FIFO_DEPTH) : drv_rdy;

    always @(posedge clk) begin
        if (bus.fifo_wr_en) begin
            log_dat[n_wr[9:0]] <= bus.fifo_wr_data;
            log_id[n_wr[9:0]]  <= bus.gnt_id;
            n_wr               <= n_wr + 1;
        end
    end

    task automatic do_reset();
        reset_n       = 1'b0;
        bus.req_valid = '0;
        drv_rdy       = 1'b1;
        model_en      = 1'b0;
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;
    endtask

    task automatic test_reset();
        int base;
        bus.req_valid = '0;
        bus.req_data  = {8'h4C, 8'h3C, 8'h2C, 8'h1C};
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;
        bus.req_valid = 4'b1111;
        @(negedge clk);
        @(negedge clk);
        n_checks++; if (bus.gnt_val !== 1'b1) begin n_errors++; $display("FAIL rst_first_gnt_val: got %0h want 1", bus.gnt_val); end
        n_checks++; if (bus.gnt_id !== 2'd0) begin n_errors++; $display("FAIL rst_first_gnt_id: got %0d want 0", bus.gnt_id); end
        @(negedge clk);
        #1 reset_n = 1'b0;
        base = n_wr;
        #1;
        n_checks++; if (bus.gnt_val !== 1'b0) begin n_errors++; $display("FAIL rst_gnt_val: got %0h want 0", bus.gnt_val); end
        n_checks++; if (bus.gnt_id !== 2'd0) begin n_errors++; $display("FAIL rst_gnt_id: got %0d want 0", bus.gnt_id); end
        n_checks++; if (bus.req_ready !== 4'b0000) begin n_errors++; $display("FAIL rst_req_ready: got %b want 0000", bus.req_ready); end
        n_checks++; if (bus.fifo_wr_en !== 1'b0) begin n_errors++; $display("FAIL rst_wr_en: got %0h want 0", bus.fifo_wr_en); end
        n_checks++; if (bus.fifo_wr_data !== 8'h00) begin n_errors++; $display("FAIL rst_wr_data: got %0h want 00", bus.fifo_wr_data); end
        repeat (2) @(negedge clk);
        n_checks++; if (n_wr !== base) begin n_errors++; $display("FAIL rst_no_write: got %0d writes want 0", n_wr - base); end
        reset_n = 1'b1;
        @(negedge clk);
        n_checks++; if (bus.gnt_val !== 1'b1) begin n_errors++; $display("FAIL rst_regrant_val: got %0h want 1", bus.gnt_val); end
        n_checks++; if (bus.gnt_id !== 2'd0) begin n_errors++; $display("FAIL rst_regrant_id: got %0d want 0", bus.gnt_id); end
    endtask

    task automatic test_round_robin();
        logic            exp_act;
        logic [ID_W-1:0] exp_id;
        logic [3:0]      exp_rdy;
        logic [7:0]      exp_dat;
        do_reset();
        bus.req_data  = {8'h4C, 8'h3C, 8'h2C, 8'h1C};
        bus.req_valid = 4'b1111;
        // Cycle c: 0 is the arbitration cycle, then 4 beats + 1 idle per grant.
        for (int c = 0; c <= 25; c++) begin
            @(negedge clk);
            exp_act = (c > 0) && (((c - 1) % 5) != 4);
            exp_id  = ID_W'(((c - 1) / 5) % 4);
            exp_rdy = exp_act ? (4'b0001 << exp_id) : 4'b0000;
            exp_dat = exp_act ? (8'h1C + {2'b00, exp_id, 4'h0}) : 8'h00;
            n_checks++; if (bus.gnt_val !== exp_act) begin n_errors++; $display("FAIL rr_gnt_val c=%0d: got %0h want %0h", c, bus.gnt_val, exp_act); end
            n_checks++; if (bus.fifo_wr_en !== exp_act) begin n_errors++; $display("FAIL rr_wr_en c=%0d: got %0h want %0h", c, bus.fifo_wr_en, exp_act); end
            n_checks++; if (bus.req_ready !== exp_rdy) begin n_errors++; $display("FAIL rr_req_ready c=%0d: got %b want %b", c, bus.req_ready, exp_rdy); end
            n_checks++; if (bus.fifo_wr_data !== exp_dat) begin n_errors++; $display("FAIL rr_wr_data c=%0d: got %0h want %0h", c, bus.fifo_wr_data, exp_dat); end
            if (exp_act) begin
                n_checks++; if (bus.gnt_id !== exp_id) begin n_errors++; $display("FAIL rr_gnt_id c=%0d: got %0d want %0d", c, bus.gnt_id, exp_id); end
            end
        end
    endtask

    task automatic test_short_burst();
        int base;
        do_reset();
        base = n_wr;
        bus.req_data  = {8'h4C, 8'h3C, 8'h2C, 8'h1C};
        bus.req_valid = 4'b0100;
        @(negedge clk);
        n_checks++; if (bus.gnt_val !== 1'b0) begin n_errors++; $display("FAIL sb_arb_cycle_val: got %0h want 0", bus.gnt_val); end
        @(negedge clk);
        n_checks++; if (bus.gnt_id !== 2'd2) begin n_errors++; $display("FAIL sb_gnt_id: got %0d want 2", bus.gnt_id); end
        n_checks++; if (bus.fifo_wr_data !== 8'h3C) begin n_errors++; $display("FAIL sb_wr_data: got %0h want 3c", bus.fifo_wr_data); end
        @(posedge clk);
        @(posedge clk);
        #1 bus.req_valid = 4'b0000;
        @(negedge clk);
        n_checks++; if (bus.fifo_wr_en !== 1'b0) begin n_errors++; $display("FAIL sb_drop_wr_en: got %0h want 0", bus.fifo_wr_en); end
        n_checks++; if (n_wr - base !== 2) begin n_errors++; $display("FAIL sb_writes: got %0d want 2", n_wr - base); end
        @(posedge clk);
        #1 bus.req_valid = 4'b1001;
        @(negedge clk);
        n_checks++; if (bus.gnt_val !== 1'b0) begin n_errors++; $display("FAIL sb_idle_val: got %0h want 0", bus.gnt_val); end
        @(negedge clk);
        n_checks++; if (bus.gnt_id !== 2'd3) begin n_errors++; $display("FAIL sb_next_from_3: got %0d want 3", bus.gnt_id); end
        n_checks++; if (log_dat[base[9:0]] !== 8'h3C) begin n_errors++; $display("FAIL sb_fifo_word0: got %0h want 3c", log_dat[base[9:0]]); end
    endtask

    task automatic test_backpressure();
        int base;
        do_reset();
        base = n_wr;
        bus.req_data  = {8'h4C, 8'h3C, 8'h2C, 8'h1C};
        bus.req_valid = 4'b0011;
        repeat (3) @(negedge clk);
        @(posedge clk);
        #1 drv_rdy = 1'b0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            n_checks++; if (bus.fifo_wr_en !== 1'b0) begin n_errors++; $display("FAIL bp_wr_en k=%0d: got %0h want 0", k, bus.fifo_wr_en); end
            n_checks++; if (bus.req_ready !== 4'b0000) begin n_errors++; $display("FAIL bp_req_ready k=%0d: got %b want 0000", k, bus.req_ready); end
            n_checks++; if ({bus.gnt_val, bus.gnt_id} !== 3'b100) begin n_errors++; $display("FAIL bp_gnt k=%0d: got %0h/%0d want 1/0", k, bus.gnt_val, bus.gnt_id); end
        end
        n_checks++; if (n_wr - base !== 2) begin n_errors++; $display("FAIL bp_frozen_writes: got %0d want 2", n_wr - base); end
        @(posedge clk);
        #1 drv_rdy = 1'b1;
        @(negedge clk);
        @(negedge clk);
        n_checks++; if ({bus.fifo_wr_en, bus.gnt_id} !== 3'b100) begin n_errors++; $display("FAIL bp_beat4: got %0h/%0d want 1/0", bus.fifo_wr_en, bus.gnt_id); end
        @(negedge clk);
        n_checks++; if (bus.gnt_val !== 1'b0) begin n_errors++; $display("FAIL bp_release: got %0h want 0", bus.gnt_val); end
        n_checks++; if (n_wr - base !== 4) begin n_errors++; $display("FAIL bp_total_beats: got %0d want 4", n_wr - base); end
        @(negedge clk);
        n_checks++; if (bus.gnt_id !== 2'd1) begin n_errors++; $display("FAIL bp_next_gnt: got %0d want 1", bus.gnt_id); end
    endtask

    task automatic test_fifo_full();
        logic [7:0]      exp_dat;
        logic [ID_W-1:0] exp_id;
        do_reset();
        fifo_base     = n_wr;
        model_en      = 1'b1;
        bus.req_data  = {8'hA3, 8'hA2, 8'hA1, 8'hA0};
        bus.req_valid = 4'b0111;
        repeat (40) @(negedge clk);
        n_checks++; if (n_wr - fifo_base !== 8) begin n_errors++; $display("FAIL ff_write_count: got %0d want 8", n_wr - fifo_base); end
        n_checks++; if ({bus.gnt_val, bus.gnt_id} !== 3'b110) begin n_errors++; $display("FAIL ff_hold_gnt: got %0h/%0d want 1/2", bus.gnt_val, bus.gnt_id); end
        n_checks++; if ({bus.fifo_wr_en, bus.req_ready} !== 5'b0) begin n_errors++; $display("FAIL ff_hold_idle: got en=%0h rdy=%b want 0/0000", bus.fifo_wr_en, bus.req_ready); end
        for (int k = 0; k < 8; k++) begin
            exp_dat = (k < 4) ? 8'hA0 : 8'hA1;
            exp_id  = (k < 4) ? 2'd0 : 2'd1;
            n_checks++; if (log_dat[10'(fifo_base + k)] !== exp_dat) begin n_errors++; $display("FAIL ff_data k=%0d: got %0h want %0h", k, log_dat[10'(fifo_base + k)], exp_dat); end
            n_checks++; if (log_id[10'(fifo_base + k)] !== exp_id) begin n_errors++; $display("FAIL ff_order k=%0d: got %0d want %0d", k, log_id[10'(fifo_base + k)], exp_id); end
        end
    endtask

    task automatic test_reset_mid_burst();
        int base;
        do_reset();
        base = n_wr;
        bus.req_data  = {8'h4C, 8'h3C, 8'h2C, 8'h1C};
        bus.req_valid = 4'b1111;
        repeat (8) @(negedge clk);
        n_checks++; if ({bus.fifo_wr_en, bus.gnt_id} !== 3'b101) begin n_errors++; $display("FAIL rm_beat2_pending: got %0h/%0d want 1/1", bus.fifo_wr_en, bus.gnt_id); end
        n_checks++; if (n_wr - base !== 5) begin n_errors++; $display("FAIL rm_pre_writes: got %0d want 5", n_wr - base); end
        #1 reset_n = 1'b0;
        #1;
        n_checks++; if ({bus.fifo_wr_en, bus.req_ready, bus.gnt_val} !== 6'b0) begin n_errors++; $display("FAIL rm_outputs: got en=%0h rdy=%b val=%0h want 0", bus.fifo_wr_en, bus.req_ready, bus.gnt_val); end
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_checks++; if (n_wr - base !== 5) begin n_errors++; $display("FAIL rm_no_write_in_reset: got %0d want 5", n_wr - base); end
        reset_n = 1'b1;
        @(negedge clk);
        n_checks++; if ({bus.gnt_val, bus.gnt_id} !== 3'b100) begin n_errors++; $display("FAIL rm_restart_rr0: got %0h/%0d want 1/0", bus.gnt_val, bus.gnt_id); end
    endtask

    initial begin
        bus.req_valid = '0;
        bus.req_data  = '0;
        test_reset();
        test_round_robin();
        test_short_burst();
        test_backpressure();
        test_fifo_full();
        test_reset_mid_burst();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
